// File: rtl/arc4_key_dispatcher.sv
// ARC4 key-search dispatcher: walks the key space and hands one candidate per cycle to NUM_CORES crack cores.
// Optional: define ARC4_DISP_PERF_EN to add the keys_tried dispatch counter output.

module arc4_disp_lane #(
    parameter int KEY_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant,
    input  logic             done,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             core_en,
    output logic [KEY_W-1:0] core_key
);
    // core_key is held until this lane is granted again so a hit can be traced back to its key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            core_en  <= 1'b0;
            core_key <= '0;
        end else begin
            core_en <= grant;
            if (grant) begin
                busy     <= 1'b1;
                core_key <= key;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

module arc4_key_dispatcher #(
    parameter int          KEY_W     = 24,
    parameter int          NUM_CORES = 2,
    parameter int unsigned KEY_START = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic                       rdy,
    output logic [NUM_CORES-1:0]       core_en,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic [NUM_CORES-1:0]       core_rdy,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_hit,
    output logic                       found,
    output logic [KEY_W-1:0]           key_out
`ifdef ARC4_DISP_PERF_EN
    ,
    output logic [KEY_W:0]             keys_tried
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [KEY_W-1:0] KEY_MAX   = '1;
    localparam logic [KEY_W-1:0] START_KEY = KEY_W'(KEY_START);

    state_t                          state_q, state_d;
    logic   [KEY_W-1:0]              next_key_q;
    logic                            exhausted_q;
    logic   [NUM_CORES-1:0]          busy;
    logic   [NUM_CORES-1:0]          busy_nxt;
    logic   [NUM_CORES-1:0]          grant;
    logic                            any_grant;
    logic                            hit_any;
    logic   [KEY_W-1:0]              hit_key;
    logic   [NUM_CORES-1:0][KEY_W-1:0] lane_key;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_lane
            arc4_disp_lane #(.KEY_W(KEY_W)) u_lane (
                .clk      (clk),
                .rst      (rst),
                .grant    (grant[gi]),
                .done     (core_done[gi]),
                .key      (next_key_q),
                .busy     (busy[gi]),
                .core_en  (core_en[gi]),
                .core_key (lane_key[gi])
            );
        end
    endgenerate

    assign core_key = lane_key;
    assign rdy      = (state_q == S_IDLE);

    // Busy is the registered value, so a core reporting done and rdy together waits one cycle.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        if (state_q == S_RUN && !exhausted_q) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_rdy[i] && !busy[i] && !any_grant) begin
                    grant[i]  = 1'b1;
                    any_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_any = 1'b0;
        hit_key = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_done[i] && core_hit[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_key = lane_key[i];
            end
        end
    end

    assign busy_nxt = (busy & ~core_done) | grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (hit_any || exhausted_q || (any_grant && next_key_q == KEY_MAX))
                         state_d = S_DRAIN;
            S_DRAIN: if (busy_nxt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_key_q  <= START_KEY;
            exhausted_q <= 1'b0;
            found       <= 1'b0;
            key_out     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                if (en) begin
                    found       <= 1'b0;
                    key_out     <= '0;
                    next_key_q  <= START_KEY;
                    exhausted_q <= 1'b0;
                end
            end else begin
                // the key counter stops at the top of the space instead of wrapping
                if (any_grant) begin
                    if (next_key_q == KEY_MAX) exhausted_q <= 1'b1;
                    else                       next_key_q  <= next_key_q + KEY_W'(1);
                end
                if (hit_any && !found) begin
                    found   <= 1'b1;
                    key_out <= hit_key;
                end
            end
        end
    end

`ifdef ARC4_DISP_PERF_EN
    localparam logic [KEY_W:0] TRIED_MAX = {1'b1, {KEY_W{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       keys_tried <= '0;
        else if (state_q == S_IDLE && en)              keys_tried <= '0;
        else if (any_grant && keys_tried != TRIED_MAX) keys_tried <= keys_tried + (KEY_W+1)'(1);
    end
`endif
endmodule
